rom_port_arb: RTL and testbench

Two-requester read arbiter in front of the synchronous-read instruction ROM. It shares the ROM's single read port between the instruction-fetch stage (F) and a data-side constant/literal load port (D). It provides a request/grant handshake, starvation-bounded priority, and per-owner response routing with error flagging. It sits between the core's fetch and load units and the `rom` instance, driving its address input and consuming its registered read data.

---
 rtl/rom_arb_pkg.sv | 18 +
 rtl/rom_port_arb_if.sv | 12 +
 rtl/rom_arb_starve_ctr.sv | 32 +++
 rtl/rom_port_arb.sv | 73 +++++++
 tb/tb_rom_port_arb.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared types, defaults and address legality helper for rom_port_arb
package rom_arb_pkg;

    localparam int DEF_DEPTH      = 32;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_F    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // Word-aligned and inside the ROM; anything else is answered with an error response.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] == 2'b00) && ((addr >> 2) < depth);
    endfunction

endpackage

// File: rtl/rom_port_arb_if.sv
// rtl/rom_port_arb_if.sv - one requester read port: request/grant plus routed response
interface rom_port_arb_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, addr, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/rom_arb_starve_ctr.sv
// rtl/rom_arb_starve_ctr.sv - saturating count of consecutive denied fetch cycles
module rom_arb_starve_ctr #(
    parameter int MAX = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);
    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != W'(MAX)))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // With MAX == 0 the count never leaves zero, so fetch always has priority.
    assign at_max_o = (cnt_q == W'(MAX));
endmodule

// File: rtl/rom_port_arb.sv
// rtl/rom_port_arb.sv - fetch/data arbiter sharing the instruction ROM read port
module rom_port_arb
    import rom_arb_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    rom_port_arb_if.slave   f_if,
    rom_port_arb_if.slave   d_if,
    input  logic            f_flush_i,
    output logic [31:0]     rom_a_o,
    input  logic [31:0]     rom_rd_i
);
    logic   at_max;
    logic   f_win, d_win;
    logic   f_ok, d_ok;
    owner_e owner_d, owner_q;
    logic   err_d, err_q;
    logic   f_rv, d_rv;

    rom_arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .inc_i    (f_if.req & ~f_win & ~f_flush_i),
        .clr_i    (f_win | ~f_if.req),
        .at_max_o (at_max)
    );

    always_comb begin
        f_win   = f_if.req & ~f_flush_i & (~d_if.req | at_max);
        d_win   = d_if.req & ~f_win;
        f_ok    = addr_ok(f_if.addr, DEPTH);
        d_ok    = addr_ok(d_if.addr, DEPTH);
        owner_d = OWN_NONE;
        err_d   = 1'b0;
        rom_a_o = '0;
        if (f_win) begin
            owner_d = OWN_F;
            err_d   = ~f_ok;
            if (f_ok) rom_a_o = f_if.addr;
        end else if (d_win) begin
            owner_d = OWN_D;
            err_d   = ~d_ok;
            if (d_ok) rom_a_o = d_if.addr;
        end
        // Reset must quiet the combinational outputs too, not just the registers.
        if (!rst_ni) rom_a_o = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    assign f_rv = (owner_q == OWN_F) & ~f_flush_i;
    assign d_rv = (owner_q == OWN_D);

    assign f_if.gnt    = f_win & rst_ni;
    assign d_if.gnt    = d_win & rst_ni;
    assign f_if.rvalid = f_rv;
    assign d_if.rvalid = d_rv;
    assign f_if.err    = f_rv & err_q;
    assign d_if.err    = d_rv & err_q;
    assign f_if.rdata  = (f_rv & ~err_q) ? rom_rd_i : '0;
    assign d_if.rdata  = (d_rv & ~err_q) ? rom_rd_i : '0;
endmodule

// File: tb/tb_rom_port_arb.sv
// tb/tb_rom_port_arb.sv - directed vector bench for rom_port_arb
module tb_rom_port_arb;
    import rom_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_flush = 1'b0;
    logic [31:0] rom_a;
    logic [31:0] rom_rd = '0;
    logic [31:0] mem [0:31];
    int          checks = 0;
    int          errors = 0;

    rom_port_arb_if f_if();
    rom_port_arb_if d_if();

    rom_port_arb #(.DEPTH(32), .STARVE_MAX(4)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .f_if      (f_if),
        .d_if      (d_if),
        .f_flush_i (f_flush),
        .rom_a_o   (rom_a),
        .rom_rd_i  (rom_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_rd <= mem[rom_a[6:2]];

    typedef struct {
        logic        f_req;
        logic [31:0] f_addr;
        logic        f_flush;
        logic        d_req;
        logic [31:0] d_addr;
        logic [1:0]  gnt;
        logic [31:0] rom_a;
        logic [33:0] f_rsp;
        logic [33:0] d_rsp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] rw(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    function automatic logic [33:0] rsp(input logic v, input logic e, input logic [31:0] d);
        return {v, e, d};
    endfunction

    function automatic vec_t mk(input logic fr, input logic [31:0] fa, input logic ff,
                                input logic dr, input logic [31:0] da, input logic [1:0] g,
                                input logic [31:0] ra, input logic [33:0] fs, input logic [33:0] ds);
        vec_t v;
        v.f_req = fr; v.f_addr = fa; v.f_flush = ff; v.d_req = dr; v.d_addr = da;
        v.gnt = g; v.rom_a = ra; v.f_rsp = fs; v.d_rsp = ds;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic [31:0] fa, input logic ff,
                         input logic dr, input logic [31:0] da);
        f_if.req = fr; f_if.addr = fa; f_flush = ff; d_if.req = dr; d_if.addr = da;
    endtask

    task automatic chk_all(input string nm, input logic [1:0] g, input logic [31:0] ra,
                           input logic [33:0] fs, input logic [33:0] ds);
        chk({nm, ".gnt"},   64'({f_if.gnt, d_if.gnt}), 64'(g));
        chk({nm, ".rom_a"}, 64'(rom_a), 64'(ra));
        chk({nm, ".f_rsp"}, 64'({f_if.rvalid, f_if.err, f_if.rdata}), 64'(fs));
        chk({nm, ".d_rsp"}, 64'({d_if.rvalid, d_if.err, d_if.rdata}), 64'(ds));
    endtask

    localparam logic [33:0] NO = 34'h0;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = rw(i);

        // Requests present while in reset: everything must stay quiet.
        drive(1'b1, 32'h4, 1'b0, 1'b1, 32'h8);
        @(negedge clk);
        chk_all("reset", 2'b00, 32'h0, NO, NO);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        vecs.push_back(mk(1, 32'h0,  0, 0, 32'h0,  2'b10, 32'h0,  NO, NO));
        vecs.push_back(mk(1, 32'h4,  0, 0, 32'h0,  2'b10, 32'h4,  rsp(1, 0, rw(0)), NO));
        vecs.push_back(mk(1, 32'h8,  0, 0, 32'h0,  2'b10, 32'h8,  rsp(1, 0, rw(1)), NO));
        vecs.push_back(mk(0, 32'h0,  0, 0, 32'h0,  2'b00, 32'h0,  rsp(1, 0, rw(2)), NO));
        vecs.push_back(mk(1, 32'h10, 0, 1, 32'h20, 2'b01, 32'h20, NO, NO));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 32'h10, 0, 1, 32'h20, 2'b01, 32'h20, NO, rsp(1, 0, rw(8))));
        vecs.push_back(mk(1, 32'h10, 0, 1, 32'h20, 2'b10, 32'h10, NO, rsp(1, 0, rw(8))));
        vecs.push_back(mk(1, 32'h10, 0, 1, 32'h20, 2'b01, 32'h20, rsp(1, 0, rw(4)), NO));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 32'h10, 0, 1, 32'h20, 2'b01, 32'h20, NO, rsp(1, 0, rw(8))));
        vecs.push_back(mk(1, 32'h10, 0, 1, 32'h20, 2'b10, 32'h10, NO, rsp(1, 0, rw(8))));
        vecs.push_back(mk(0, 32'h0,  0, 0, 32'h0,  2'b00, 32'h0,  rsp(1, 0, rw(4)), NO));
        vecs.push_back(mk(0, 32'h0,  0, 1, 32'h202, 2'b01, 32'h0, NO, NO));
        vecs.push_back(mk(0, 32'h0,  0, 0, 32'h0,  2'b00, 32'h0,  NO, rsp(1, 1, 32'h0)));
        vecs.push_back(mk(1, 32'h80, 0, 0, 32'h0,  2'b10, 32'h0,  NO, NO));
        vecs.push_back(mk(1, 32'h7C, 0, 0, 32'h0,  2'b10, 32'h7C, rsp(1, 1, 32'h0), NO));
        vecs.push_back(mk(0, 32'h0,  0, 0, 32'h0,  2'b00, 32'h0,  rsp(1, 0, rw(31)), NO));
        vecs.push_back(mk(1, 32'h0,  0, 0, 32'h0,  2'b10, 32'h0,  NO, NO));
        vecs.push_back(mk(1, 32'hC,  1, 1, 32'h14, 2'b01, 32'h14, NO, NO));
        vecs.push_back(mk(0, 32'h0,  0, 0, 32'h0,  2'b00, 32'h0,  NO, rsp(1, 0, rw(5))));

        foreach (vecs[i]) begin
            drive(vecs[i].f_req, vecs[i].f_addr, vecs[i].f_flush, vecs[i].d_req, vecs[i].d_addr);
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].rom_a, vecs[i].f_rsp, vecs[i].d_rsp);
            @(posedge clk); #1;
        end

        // Build the starvation count to 3, then reset with a D response in flight.
        drive(1'b1, 32'h10, 1'b0, 1'b1, 32'h20);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("pre_rst%0d.gnt", i), 64'({f_if.gnt, d_if.gnt}), 64'(2'b01));
            @(posedge clk);
        end
        #2 rst_n = 1'b0;
        #1 chk_all("mid_rst", 2'b00, 32'h0, NO, NO);
        @(negedge clk);
        chk_all("hold_rst", 2'b00, 32'h0, NO, NO);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d.gnt", i), 64'({f_if.gnt, d_if.gnt}),
                64'((i == 4) ? 2'b10 : 2'b01));
            if (i == 0) chk("post_rst0.d_rsp", 64'({d_if.rvalid, d_if.err, d_if.rdata}), 64'(NO));
            if (i == 1) chk("post_rst1.d_rsp", 64'({d_if.rvalid, d_if.err, d_if.rdata}),
                            64'(rsp(1, 0, rw(8))));
            @(posedge clk); #1;
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
